adc_frontend: RTL and testbench
===============================

# adc_frontend

Sample-acquisition stage that sits directly upstream of the second-order IIR filter. It generates the ADC sample clock from the system clock and captures the 8-bit ADC byte at a fixed settled phase. Each capture is converted to the filter's 9-bit signed input format and buffered in a small FIFO with a valid/ready handshake. Dropped samples are flagged and counted so the filter path can detect lost data.

## Interface
- DIV_HALF, 6: half-period of adc_clk in clk cycles; sample rate = clk/(2·DIV_HALF), giving 1 MHz at 12 MHz. Legal range ≥2.
- CAPTURE_PHASE, 3: counter value, during the adc_clk high half, at which adc is captured. Must be < DIV_HALF.
- FIFO_DEPTH, 4: sample buffer depth, power of two, ≥2.
- OFFSET_BINARY, 1: 1 = ADC output is offset binary; 0 = ADC output is plain unsigned.
- clk  in  1  system clock (12 MHz); the only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- adc  in  8  ADC data bus, valid from adc_clk rising edge + ADC output delay.
- adc_clk  out  1  ADC sample clock, registered, 50% duty.
- s_data  out  9  signed sample to the filter (FIFO head).
- s_valid  out  1  FIFO not empty.
- s_ready  in  1  consumer accepts s_data this cycle.
- clear  in  1  synchronous clear of overrun and ovr_count.
- overrun  out  1  sticky: at least one sample was dropped.
- ovr_count  out  8  dropped-sample count, saturates at 255.

## Operation
- Divider: a counter runs 0..DIV_HALF-1. At count DIV_HALF-1 the counter wraps to 0 and adc_clk toggles.
- Capture: on a clk edge where adc_clk==1 and counter==CAPTURE_PHASE, adc is registered into raw. The same edge raises an internal cap_v pulse for one cycle.
- Convert (one registered stage, following cap_v):
  - OFFSET_BINARY=1: s = {~raw[7], ~raw[7], raw[6:0]}, range -128..127.
  - OFFSET_BINARY=0: s = {1'b0, raw}, range 0..255.
- FIFO:
  - First-word fall-through, in-order.
  - Push occurs on the cycle after conversion. Pop = s_valid & s_ready.
  - When full, a push is accepted only if a pop happens in the same cycle. Otherwise the new sample is dropped, overrun is set to 1, and ovr_count increments, saturating at 255.
  - A push into an empty FIFO with s_ready=1 is not popped until the next cycle, because s_valid is registered.
- clear: overrun←0 and ovr_count←0 on the next edge; the FIFO contents are untouched. If clear and a drop occur in the same cycle, clear wins: the counter becomes 0 and the drop is not counted.
- s_data holds the head value while s_valid=1 and s_ready=0. s_data is don't-care while s_valid=0 and is driven as 0.

## Timing
- Reset values: adc_clk=0, counter=0, s_valid=0, s_data=0, overrun=0, ovr_count=0, FIFO empty, cap_v=0.
- Clk edges are numbered from 1 after rst deasserts.
  - First adc_clk rise: edge DIV_HALF (edge 6 for defaults).
  - First capture: edge DIV_HALF+1+CAPTURE_PHASE (edge 10).
  - Subsequent captures: every 2·DIV_HALF edges (12).
- Latency from capture to FIFO push is 2 edges: the conversion register updates at capture+1, and the FIFO write occurs at capture+2. s_valid is high after edge capture+2 (edge 12) when the FIFO was empty.
- Capture to adc_clk falling edge: DIV_HALF-1-CAPTURE_PHASE cycles. The ADC must hold its data until then.
- Reset asserted mid-operation forces every register to its reset value immediately (asynchronously): adc_clk drops and in-flight and buffered samples are discarded. After release, the divider restarts from count 0.
- Sustained throughput is one sample per 2·DIV_HALF cycles. The consumer must pop at least that often to avoid overrun.

## Test plan
- Reset: hold rst 3 cycles mid-stream with the FIFO holding 2 samples → all outputs are at reset values during rst. After release, the first adc_clk rise is at edge 6, the first s_valid rise is at edge 12, and adc_clk has a 12-cycle period with 6 cycles high.
- Conversion (OFFSET_BINARY=1): adc=0x80, 0xFF, 0x00, 0x7F on successive samples with s_ready=1 → s_data = 0x000, 0x07F, 0x180, 0x1FF. With OFFSET_BINARY=0, adc=0xFF → 0x0FF.
- Backpressure: s_ready=0 for 5 sample periods with adc = 1, 2, 3, 4, 5 → after the 5th capture, overrun=1 and ovr_count=1. Then s_ready=1 drains 1, 2, 3, 4 in order, and s_valid falls after the 4th pop.
- Full with simultaneous pop: FIFO full, s_ready=1 exactly on the push cycle → sample accepted, overrun stays 0, occupancy stays 4.
- Saturation and clear: s_ready=0 for 300 sample periods → ovr_count=255 and overrun=1. Pulse clear for 1 cycle → both become 0 on the next edge, and the FIFO still holds 4 samples. Clear coincident with a drop → ovr_count=0.

Source files
------------

// File: rtl/adc_frontend.sv
// ADC acquisition front end: divides clk to the ADC sample clock, captures the ADC byte at a
// settled phase, converts it to the filter's 9-bit signed format and buffers it in a FWFT FIFO.
`timescale 1ns/1ps

module adc_frontend #(
  parameter int DIV_HALF      = 6,
  parameter int CAPTURE_PHASE = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc,
  output logic       adc_clk,
  output logic [8:0] s_data,
  output logic       s_valid,
  input  logic       s_ready,
  input  logic       clear,
  output logic       overrun,
  output logic [7:0] ovr_count
);

  localparam int CNT_W = $clog2(DIV_HALF);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adc_clk_q, adc_clk_d;
  logic [7:0]       raw_q, raw_d;
  logic             cap_v_q, cap_v_d;
  logic [8:0]       conv_q, conv_d;
  logic             conv_v_q, conv_v_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       ovr_count_q, ovr_count_d;
  logic [8:0]       mem_q [FIFO_DEPTH];

  logic cap_hit, full, pop, wr_en, drop;

  // NOTE: every _d is given its hold value before any branch, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    adc_clk_d = adc_clk_q;
    if (cnt_q == CNT_W'(DIV_HALF - 1)) begin
      cnt_d     = '0;
      adc_clk_d = ~adc_clk_q;
    end
  end

  // Capture well after the ADC output delay but before adc_clk falls and the ADC may change.
  assign cap_hit = adc_clk_q && (cnt_q == CNT_W'(CAPTURE_PHASE));

  always_comb begin
    raw_d    = cap_hit ? adc : raw_q;
    cap_v_d  = cap_hit;
    conv_v_d = cap_v_q;
    conv_d   = conv_q;
    if (cap_v_q) begin
      if (OFFSET_BINARY) conv_d = {~raw_q[7], ~raw_q[7], raw_q[6:0]};
      else               conv_d = {1'b0, raw_q};
    end
  end

  assign s_valid = (count_q != '0);
  assign full    = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop     = s_valid && s_ready;
  assign wr_en   = conv_v_q && (!full || pop);
  assign drop    = conv_v_q && full && !pop;
  assign s_data  = s_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (PTR_W + 1)'(1);
  end

  // Clear has priority so a drop in the same cycle is not counted.
  always_comb begin
    overrun_d   = overrun_q;
    ovr_count_d = ovr_count_q;
    if (clear) begin
      overrun_d   = 1'b0;
      ovr_count_d = '0;
    end else if (drop) begin
      overrun_d = 1'b1;
      if (ovr_count_q != 8'hFF) ovr_count_d = ovr_count_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      adc_clk_q   <= 1'b0;
      raw_q       <= '0;
      cap_v_q     <= 1'b0;
      conv_q      <= '0;
      conv_v_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      ovr_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      adc_clk_q   <= adc_clk_d;
      raw_q       <= raw_d;
      cap_v_q     <= cap_v_d;
      conv_q      <= conv_d;
      conv_v_q    <= conv_v_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  // NOTE: sample storage has no reset; an empty count hides stale entries and s_data is gated to 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= conv_q;
  end

  assign adc_clk   = adc_clk_q;
  assign overrun   = overrun_q;
  assign ovr_count = ovr_count_q;

endmodule

// File: tb/tb_adc_frontend.sv
// Scoreboard bench for adc_frontend: expected samples are queued when the ADC byte is driven
// at each adc_clk rise and compared against s_data whenever the consumer pops.
`timescale 1ns/1ps

module tb_adc_frontend;

  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] adc;
  logic       adc_clk, adc_clk_ub;
  logic [8:0] s_data, s_data_ub;
  logic       s_valid, s_valid_ub;
  logic       s_ready;
  logic       clear;
  logic       overrun, overrun_ub;
  logic [7:0] ovr_count, ovr_count_ub;

  adc_frontend u_dut (
    .clk(clk), .rst(rst), .adc(adc), .adc_clk(adc_clk), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .clear(clear), .overrun(overrun), .ovr_count(ovr_count)
  );

  adc_frontend #(.OFFSET_BINARY(1'b0)) u_dut_ub (
    .clk(clk), .rst(rst), .adc(adc), .adc_clk(adc_clk_ub), .s_data(s_data_ub),
    .s_valid(s_valid_ub), .s_ready(1'b1), .clear(clear), .overrun(overrun_ub),
    .ovr_count(ovr_count_ub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [8:0] sb [$];
  logic [7:0] next_adc;
  bit         force_accept;
  bit         adc_prev;
  int         exp_ovr;
  bit         exp_overrun;

  // Offset binary maps 0x80 to zero: subtract the mid-code and keep 9 bits of two's complement.
  function automatic logic [8:0] ob_conv(input logic [7:0] v);
    return 9'(int'(v) - 128);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rise();
    bit prev = adc_clk;
    bit seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (adc_clk && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = adc_clk;
    end
    if (!seen) check("adc_clk_rise_timeout", 32'(seen), 32'd1);
  endtask

  // Returns one edge after the rise, once the driver has consumed next_adc.
  task automatic next_sample(input logic [7:0] v);
    next_adc = v;
    wait_rise();
    step();
  endtask

  task automatic quiesce();
    s_ready = 1'b1;
    wait_rise();
    step(7);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_adc_clk"}, 32'(adc_clk), 32'd0);
    check({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_s_data"}, 32'(s_data), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_ovr_count"}, 32'(ovr_count), 32'd0);
  endtask

  // Monitor pops on handshake; driver presents the next byte on each adc_clk rise and predicts
  // whether the FIFO will still have room when that sample arrives.
  initial begin
    adc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s_valid && s_ready) begin
          if (sb.size() == 0) check("pop_without_expected", 32'(sb.size()), 32'd1);
          else check("s_data", 32'(s_data), 32'(sb.pop_front()));
        end
        if (adc_clk && !adc_prev) begin
          adc = next_adc;
          if (sb.size() >= FIFO_DEPTH && !force_accept) begin
            exp_overrun = 1'b1;
            if (exp_ovr < 255) exp_ovr++;
          end else begin
            sb.push_back(ob_conv(next_adc));
          end
        end
      end
      adc_prev = adc_clk;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n_valid, first_rise, first_fall, second_rise, first_valid;
    rst = 1'b1; s_ready = 1'b1; clear = 1'b0; adc = 8'h00; next_adc = 8'h80;
    force_accept = 1'b0; exp_ovr = 0; exp_overrun = 1'b0;

    step(3);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Conversion, consumer always ready
    next_sample(8'h80);
    next_sample(8'hFF);
    step(5);
    check("ub_s_valid", 32'(s_valid_ub), 32'd1);
    check("ub_s_data", 32'(s_data_ub), 32'h0FF);
    next_sample(8'h00);
    next_sample(8'h7F);
    step(6);
    check("conv_drained", 32'(sb.size()), 32'd0);
    check("conv_idle_valid", 32'(s_valid), 32'd0);
    check("conv_idle_data", 32'(s_data), 32'd0);

    // Full FIFO with a pop on the push cycle
    s_ready = 1'b0;
    for (int v = 16; v < 20; v++) next_sample(8'(v));
    force_accept = 1'b1;
    next_sample(8'h14);
    step(4);
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    force_accept = 1'b0;
    check("fullpop_overrun", 32'(overrun), 32'd0);
    check("fullpop_ovr_count", 32'(ovr_count), 32'd0);
    s_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_valid) n_valid++;
      step();
    end
    check("fullpop_occupancy", 32'(n_valid), 32'(FIFO_DEPTH));
    check("fullpop_drained", 32'(sb.size()), 32'd0);

    // Backpressure: five samples, the fifth dropped
    quiesce();
    s_ready = 1'b0;
    for (int v = 1; v <= 5; v++) next_sample(8'(v));
    step(5);
    check("bp_overrun", 32'(overrun), 32'(exp_overrun));
    check("bp_ovr_count", 32'(ovr_count), 32'(exp_ovr));
    s_ready = 1'b1;
    step(3);
    check("bp_valid_before_last", 32'(s_valid), 32'd1);
    step();
    check("bp_valid_after_last", 32'(s_valid), 32'd0);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Saturation, clear, clear coincident with a drop
    quiesce();
    s_ready = 1'b0;
    for (int i = 0; i < 300; i++) next_sample(8'(i));
    step(5);
    check("sat_ovr_count", 32'(ovr_count), 32'd255);
    check("sat_model", 32'(ovr_count), 32'(exp_ovr));
    check("sat_overrun", 32'(overrun), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_ovr = 0; exp_overrun = 1'b0;
    check("clear_overrun", 32'(overrun), 32'd0);
    check("clear_ovr_count", 32'(ovr_count), 32'd0);
    check("clear_fifo_valid", 32'(s_valid), 32'd1);
    check("clear_fifo_kept", 32'(sb.size()), 32'(FIFO_DEPTH));
    next_sample(8'hAA);
    step(4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_ovr = 0; exp_overrun = 1'b0;
    check("clear_drop_ovr_count", 32'(ovr_count), 32'd0);
    check("clear_drop_overrun", 32'(overrun), 32'd0);
    next_sample(8'hAB);
    step(5);
    check("post_clear_ovr_count", 32'(ovr_count), 32'(exp_ovr));
    check("post_clear_overrun", 32'(overrun), 32'(exp_overrun));

    // Reset mid-stream with two samples buffered
    quiesce();
    s_ready = 1'b0;
    next_sample(8'h21);
    next_sample(8'h22);
    step(5);
    check("prerst_valid", 32'(s_valid), 32'd1);
    check("prerst_count", 32'(sb.size()), 32'd2);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    sb.delete();
    exp_ovr = 0; exp_overrun = 1'b0;
    step(3);
    check_idle_outputs("rst_held");
    rst = 1'b0;
    first_rise = 0; first_fall = 0; second_rise = 0; first_valid = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (adc_clk && first_rise == 0) first_rise = k;
      else if (!adc_clk && first_rise != 0 && first_fall == 0) first_fall = k;
      else if (adc_clk && first_fall != 0 && second_rise == 0) second_rise = k;
      if (s_valid && first_valid == 0) first_valid = k;
    end
    check("rst_first_rise", 32'(first_rise), 32'd6);
    check("rst_first_fall", 32'(first_fall), 32'd12);
    check("rst_second_rise", 32'(second_rise), 32'd18);
    check("rst_first_valid", 32'(first_valid), 32'd12);

    quiesce();
    check("final_drained", 32'(sb.size()), 32'd0);
    check("final_valid", 32'(s_valid), 32'd0);
    check("final_overrun", 32'(overrun), 32'(exp_overrun));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
